// File: rtl/tpu_seq_control.sv
// tpu_seq_control
//   Registered decode control with a sequencer for multi-cycle TPU ops.
//   Ordinary opcodes decode with one cycle of latency. TPU row ops
//   (0x51..0x54) run for DIM cycles. Matmul (0x50) waits for tpu_done_i
//   or times out. The front end is stalled while the sequencer is busy.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | decoding; accepts a new instruction when valid and not flushed
//   ROWS   | stepping rows 0..DIM-1 of lam/lbm/lacc/racc
//   MATMUL | start pulse in the first cycle, then waiting for done or timeout
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   op_i, valid_i         opcode in decode and its valid flag
//   flush_i               kills the instruction in decode
//   tpu_done_i            matmul complete (only looked at in MATMUL)
//   valid_o .. illegal_o  registered pipeline control
//   stall_o               sequencer busy; upstream holds op_i
//   tpu_*_o               TPU start, row write/read strobes, row index, timeout
module tpu_seq_control #(
    parameter int DIM        = 8,
    parameter int ROW_W      = $clog2(DIM),
    parameter int MM_TIMEOUT = 64,
    parameter int TO_W       = $clog2(MM_TIMEOUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       op_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic             tpu_done_i,
    output logic             valid_o,
    output logic             imm_sel_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       branch_type_o,
    output logic [1:0]       wb_sel_o,
    output logic             reg_write_enable_o,
    output logic             mem_write_enable_o,
    output logic             illegal_o,
    output logic             stall_o,
    output logic             tpu_start_o,
    output logic             tpu_wr_en_a_o,
    output logic             tpu_wr_en_b_o,
    output logic             tpu_wr_en_c_o,
    output logic             tpu_rd_acc_o,
    output logic [ROW_W-1:0] tpu_row_o,
    output logic             tpu_timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ROWS, S_MATMUL} state_e;

    localparam logic [6:0] OP_MATMUL = 7'h50;
    localparam logic [6:0] OP_LAM    = 7'h51;
    localparam logic [6:0] OP_LBM    = 7'h52;
    localparam logic [6:0] OP_LACC   = 7'h53;
    localparam logic [6:0] OP_RACC   = 7'h54;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [6:0]         op_q, op_d;
    logic               timeout_q, timeout_d;

    logic               dec_valid_q, dec_valid_d;
    logic               dec_imm_q, dec_imm_d;
    logic [3:0]         dec_alu_q, dec_alu_d;
    logic [1:0]         dec_br_q, dec_br_d;
    logic [1:0]         dec_wb_q, dec_wb_d;
    logic               dec_rw_q, dec_rw_d;
    logic               dec_mw_q, dec_mw_d;
    logic               dec_ill_q, dec_ill_d;

    logic               accept;
    logic               is_tpu;
    logic               legal;
    logic               f_imm, f_rw, f_mw;
    logic [3:0]         f_alu;
    logic [1:0]         f_br, f_wb;

    // Only IDLE can accept, so stall is purely a function of the state register.
    assign accept = valid_i & ~flush_i & (state_q == S_IDLE);
    assign is_tpu = (op_i >= OP_MATMUL) && (op_i <= OP_RACC);

    // Field decode of op_i, independent of whether it is accepted.
    always_comb begin
        legal = 1'b0;
        f_imm = op_i[4] ^ op_i[5];
        f_alu = ((op_i == 7'h20) || (op_i == 7'h21)) ? 4'h1 : op_i[3:0];
        f_br  = 2'b00;
        f_wb  = 2'b00;
        f_rw  = 1'b0;
        f_mw  = 1'b0;
        case (op_i) inside
            7'h00: legal = 1'b1;
            [7'h01:7'h0A], 7'h11, [7'h13:7'h19], 7'h1B: begin
                legal = 1'b1;
                f_rw  = 1'b1;
            end
            7'h20: begin
                legal = 1'b1;
                f_wb  = 2'b01;
                f_rw  = 1'b1;
            end
            7'h21: begin
                legal = 1'b1;
                f_mw  = 1'b1;
            end
            [7'h3C:7'h3F]: begin
                legal = 1'b1;
                f_br  = 2'b01;
            end
            7'h7E: begin
                legal = 1'b1;
                f_br  = 2'b10;
            end
            7'h7F: begin
                legal = 1'b1;
                f_br  = 2'b11;
            end
            default: legal = 1'b0;
        endcase
    end

    // Decode register inputs. TPU ops leave these clear; the sequencer
    // drives its own outputs. Illegal ops present valid+illegal only.
    always_comb begin
        dec_valid_d = 1'b0;
        dec_imm_d   = 1'b0;
        dec_alu_d   = 4'h0;
        dec_br_d    = 2'b00;
        dec_wb_d    = 2'b00;
        dec_rw_d    = 1'b0;
        dec_mw_d    = 1'b0;
        dec_ill_d   = 1'b0;
        if (accept && !is_tpu) begin
            dec_valid_d = 1'b1;
            if (legal) begin
                dec_imm_d = f_imm;
                dec_alu_d = f_alu;
                dec_br_d  = f_br;
                dec_wb_d  = f_wb;
                dec_rw_d  = f_rw;
                dec_mw_d  = f_mw;
            end else begin
                dec_ill_d = 1'b1;
            end
        end
    end

    // Sequencer next state.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        to_d      = to_q;
        op_d      = op_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_tpu) begin
                    op_d = op_i;
                    if (op_i == OP_MATMUL) begin
                        state_d = S_MATMUL;
                        to_d    = '0;
                    end else begin
                        state_d = S_ROWS;
                        row_d   = '0;
                    end
                end
            end
            S_ROWS: begin
                if (row_q == ROW_W'(DIM - 1)) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            S_MATMUL: begin
                // done is checked first so it wins over a coincident timeout
                if (tpu_done_i) begin
                    state_d = S_IDLE;
                    to_d    = '0;
                end else if (to_q == TO_W'(MM_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    to_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            to_q        <= '0;
            op_q        <= '0;
            timeout_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_imm_q   <= 1'b0;
            dec_alu_q   <= 4'h0;
            dec_br_q    <= 2'b00;
            dec_wb_q    <= 2'b00;
            dec_rw_q    <= 1'b0;
            dec_mw_q    <= 1'b0;
            dec_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            to_q        <= to_d;
            op_q        <= op_d;
            timeout_q   <= timeout_d;
            dec_valid_q <= dec_valid_d;
            dec_imm_q   <= dec_imm_d;
            dec_alu_q   <= dec_alu_d;
            dec_br_q    <= dec_br_d;
            dec_wb_q    <= dec_wb_d;
            dec_rw_q    <= dec_rw_d;
            dec_mw_q    <= dec_mw_d;
            dec_ill_q   <= dec_ill_d;
        end
    end

    logic in_rows, in_mm, mm_first;

    assign in_rows  = (state_q == S_ROWS);
    assign in_mm    = (state_q == S_MATMUL);
    assign mm_first = in_mm && (to_q == '0);

    // Outputs come only from registers, so they stay one cycle behind accept.
    assign valid_o            = dec_valid_q | in_rows | mm_first;
    assign imm_sel_o          = dec_imm_q;
    assign alu_op_o           = dec_alu_q;
    assign branch_type_o      = dec_br_q;
    assign wb_sel_o           = (in_rows || in_mm) ? 2'b10 : dec_wb_q;
    assign reg_write_enable_o = dec_rw_q | (in_rows && (op_q == OP_RACC));
    assign mem_write_enable_o = dec_mw_q;
    assign illegal_o          = dec_ill_q;
    assign stall_o            = (state_q != S_IDLE);
    assign tpu_start_o        = mm_first;
    assign tpu_wr_en_a_o      = in_rows && (op_q == OP_LAM);
    assign tpu_wr_en_b_o      = in_rows && (op_q == OP_LBM);
    assign tpu_wr_en_c_o      = in_rows && (op_q == OP_LACC);
    assign tpu_rd_acc_o       = in_rows && (op_q == OP_RACC);
    assign tpu_row_o          = row_q;
    assign tpu_timeout_o      = timeout_q;

endmodule

// File: tb/tb_tpu_seq_control.sv
// Testbench for tpu_seq_control (DIM=8, MM_TIMEOUT=6).
// The driver pushes hand-computed expected output bundles into a queue as it
// issues stimulus; a monitor pops and compares on every cycle where the DUT
// drives any output non-zero. Cycles with all outputs 0 are expected silence.
module tb_tpu_seq_control;

    localparam int DIM = 8;
    localparam int MMT = 6;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = 7'h00;
    logic       valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       tpu_done_i = 1'b0;
    logic       valid_o, imm_sel_o, reg_write_enable_o, mem_write_enable_o;
    logic       illegal_o, stall_o, tpu_start_o, tpu_timeout_o;
    logic       tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o, tpu_rd_acc_o;
    logic [3:0] alu_op_o;
    logic [1:0] branch_type_o, wb_sel_o;
    logic [2:0] tpu_row_o;

    tpu_seq_control #(.DIM(DIM), .MM_TIMEOUT(MMT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .valid_i(valid_i),
        .flush_i(flush_i), .tpu_done_i(tpu_done_i), .valid_o(valid_o),
        .imm_sel_o(imm_sel_o), .alu_op_o(alu_op_o), .branch_type_o(branch_type_o),
        .wb_sel_o(wb_sel_o), .reg_write_enable_o(reg_write_enable_o),
        .mem_write_enable_o(mem_write_enable_o), .illegal_o(illegal_o),
        .stall_o(stall_o), .tpu_start_o(tpu_start_o),
        .tpu_wr_en_a_o(tpu_wr_en_a_o), .tpu_wr_en_b_o(tpu_wr_en_b_o),
        .tpu_wr_en_c_o(tpu_wr_en_c_o), .tpu_rd_acc_o(tpu_rd_acc_o),
        .tpu_row_o(tpu_row_o), .tpu_timeout_o(tpu_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       valid;
        logic       imm;
        logic [3:0] alu;
        logic [1:0] br;
        logic [1:0] wb;
        logic       rw;
        logic       mw;
        logic       ill;
        logic       stall;
        logic       start;
        logic       wen_a;
        logic       wen_b;
        logic       wen_c;
        logic       rd;
        logic [2:0] row;
        logic       to;
    } out_t;

    out_t obs;
    assign obs = {valid_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o,
                  reg_write_enable_o, mem_write_enable_o, illegal_o, stall_o,
                  tpu_start_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o,
                  tpu_rd_acc_o, tpu_row_o, tpu_timeout_o};

    out_t exp_q[$];
    out_t exp_cur;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    function automatic out_t dec(logic imm, logic [3:0] alu, logic [1:0] br,
                                 logic [1:0] wb, logic rw, logic mw);
        out_t o = '0;
        o.valid = 1'b1; o.imm = imm; o.alu = alu; o.br = br;
        o.wb = wb; o.rw = rw; o.mw = mw;
        return o;
    endfunction

    function automatic out_t ill_v();
        out_t o = '0;
        o.valid = 1'b1; o.ill = 1'b1;
        return o;
    endfunction

    // kind: 1 lam, 2 lbm, 3 lacc, 4 racc
    function automatic out_t row_v(int kind, int r);
        out_t o = '0;
        o.valid = 1'b1; o.wb = 2'b10; o.stall = 1'b1; o.row = 3'(r);
        o.wen_a = (kind == 1); o.wen_b = (kind == 2); o.wen_c = (kind == 3);
        o.rd = (kind == 4); o.rw = (kind == 4);
        return o;
    endfunction

    function automatic out_t mm_v(logic first);
        out_t o = '0;
        o.valid = first; o.start = first; o.stall = 1'b1; o.wb = 2'b10;
        return o;
    endfunction

    function automatic out_t to_v();
        out_t o = '0;
        o.to = 1'b1;
        return o;
    endfunction

    task automatic step(input logic [6:0] op, input logic v, input logic f, input logic d);
        op_i = op; valid_i = v; flush_i = f; tpu_done_i = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [6:0] op, input out_t e);
        exp_q.push_back(e);
        step(op, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (obs !== out_t'(0)) begin
            n_err++;
            $display("FAIL %s: got %h want 0", name, obs);
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en && obs !== out_t'(0)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h want none at %0t", obs, $time);
            end else begin
                exp_cur = exp_q.pop_front();
                if (obs !== exp_cur) begin
                    n_err++;
                    $display("FAIL output_bundle: got %h want %h at %0t", obs, exp_cur, $time);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset_state");
        rst_i = 1'b0;
        mon_en = 1'b1;

        // plain decode, back to back
        issue(7'h01, dec(1'b0, 4'h1, 2'b00, 2'b00, 1'b1, 1'b0));
        issue(7'h21, dec(1'b1, 4'h1, 2'b00, 2'b00, 1'b0, 1'b1));
        issue(7'h3D, dec(1'b0, 4'hD, 2'b01, 2'b00, 1'b0, 1'b0));
        issue(7'h7E, dec(1'b0, 4'hE, 2'b10, 2'b00, 1'b0, 1'b0));
        issue(7'h7F, dec(1'b0, 4'hF, 2'b11, 2'b00, 1'b0, 1'b0));
        issue(7'h0F, ill_v());
        issue(7'h20, dec(1'b1, 4'h1, 2'b00, 2'b01, 1'b1, 1'b0));
        issue(7'h13, dec(1'b1, 4'h3, 2'b00, 2'b00, 1'b1, 1'b0));
        issue(7'h00, dec(1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0));
        issue(7'h12, ill_v());
        issue(7'h0A, dec(1'b0, 4'hA, 2'b00, 2'b00, 1'b1, 1'b0));
        issue(7'h0B, ill_v());
        issue(7'h1B, dec(1'b1, 4'hB, 2'b00, 2'b00, 1'b1, 1'b0));
        issue(7'h3C, dec(1'b0, 4'hC, 2'b01, 2'b00, 1'b0, 1'b0));
        issue(7'h4F, ill_v());
        issue(7'h55, ill_v());
        step(7'h01, 1'b0, 1'b0, 1'b0);
        step(7'h01, 1'b1, 1'b1, 1'b0);
        idle(1);
        check_zero("not_accepted");

        // lbm with 0x01 held behind the stall
        for (int r = 0; r < DIM; r++) exp_q.push_back(row_v(2, r));
        exp_q.push_back(dec(1'b0, 4'h1, 2'b00, 2'b00, 1'b1, 1'b0));
        step(7'h52, 1'b1, 1'b0, 1'b0);
        repeat (DIM + 1) step(7'h01, 1'b1, 1'b0, 1'b0);
        idle(2);

        // racc
        for (int r = 0; r < DIM; r++) exp_q.push_back(row_v(4, r));
        step(7'h54, 1'b1, 1'b0, 1'b0);
        idle(DIM + 1);

        // flush on a lam in decode: nothing starts
        step(7'h51, 1'b1, 1'b1, 1'b0);
        check_zero("flush_lam");
        idle(2);

        // flush during lacc rows: all rows still run
        for (int r = 0; r < DIM; r++) exp_q.push_back(row_v(3, r));
        step(7'h53, 1'b1, 1'b0, 1'b0);
        repeat (DIM) step(7'h01, 1'b1, 1'b1, 1'b0);
        idle(2);

        // done while idle is ignored
        step(7'h00, 1'b0, 1'b0, 1'b1);
        check_zero("done_idle");
        idle(1);

        // matmul, done in the 5th cycle
        exp_q.push_back(mm_v(1'b1));
        repeat (4) exp_q.push_back(mm_v(1'b0));
        step(7'h50, 1'b1, 1'b0, 1'b0);
        repeat (4) step(7'h00, 1'b0, 1'b0, 1'b0);
        step(7'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // matmul timeout: MMT busy cycles then one timeout pulse
        exp_q.push_back(mm_v(1'b1));
        repeat (MMT - 1) exp_q.push_back(mm_v(1'b0));
        exp_q.push_back(to_v());
        step(7'h50, 1'b1, 1'b0, 1'b0);
        repeat (MMT) step(7'h00, 1'b0, 1'b0, 1'b0);
        idle(2);

        // done in the last allowed cycle wins over timeout
        exp_q.push_back(mm_v(1'b1));
        repeat (MMT - 1) exp_q.push_back(mm_v(1'b0));
        step(7'h50, 1'b1, 1'b0, 1'b0);
        repeat (MMT - 1) step(7'h00, 1'b0, 1'b0, 1'b0);
        step(7'h00, 1'b0, 1'b0, 1'b1);
        idle(3);

        // reset during row 3 of lam
        for (int r = 0; r < 4; r++) exp_q.push_back(row_v(1, r));
        step(7'h51, 1'b1, 1'b0, 1'b0);
        idle(3);
        rst_i = 1'b1;
        idle(1);
        check_zero("reset_mid_rows");
        rst_i = 1'b0;
        idle(DIM);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_outputs: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
